// File: rtl/flag_unit_pkg.sv
// Shared definitions for the flag unit and the control decoder: flag bit
// positions, the flag word type and the branch condition codes.
package flag_unit_pkg;

    // Flag word layout: {carry, overflow, zero}
    localparam int FLAG_W = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef logic [FLAG_W-1:0] flags_t;

    // Branch condition selector encoding
    typedef enum logic [2:0] {
        COND_ALWAYS = 3'b000,
        COND_Z      = 3'b001,
        COND_NZ     = 3'b010,
        COND_C      = 3'b011,
        COND_NC     = 3'b100,
        COND_V      = 3'b101,
        COND_NV     = 3'b110,
        COND_NEVER  = 3'b111
    } cond_e;

    // Assemble a flag word from the individual ALU status bits
    function automatic flags_t pack_flags(input logic carry,
                                          input logic overflow,
                                          input logic zero);
        flags_t f;
        f         = '0;
        f[FLAG_C] = carry;
        f[FLAG_V] = overflow;
        f[FLAG_Z] = zero;
        return f;
    endfunction

endpackage

// File: rtl/flag_stack.sv
// Flag save stack: a small LIFO of flag words used across subroutine calls
// and interrupts. Detects overflow/underflow and keeps a sticky error bit.
// A simultaneous push and pop is a no-op for the stack.
module flag_stack
    import flag_unit_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_err,
    input  flags_t        din,
    output flags_t        dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          pop_ok,
    output logic          err
);

    localparam int AW = $clog2(DEPTH);

    flags_t          r_mem [DEPTH];
    logic [CW-1:0]   r_count;
    logic            r_err;

    logic            w_full;
    logic            w_empty;
    logic            w_push_ok;
    logic            w_pop_ok;
    logic            w_error;
    logic [AW-1:0]   w_wr_idx;
    logic [AW-1:0]   w_rd_idx;

    // Occupancy decode, operation qualification and stack indexing.
    // Indices are formed in CW bits; the full/empty guards keep the used
    // index inside the array, so truncation to AW bits is exact.
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        w_full    = (r_count == CW'(DEPTH));
        w_empty   = (r_count == '0);
        w_push_ok = push && !pop && !w_full;
        w_pop_ok  = pop && !push && !w_empty;
        w_error   = (push && !pop && w_full) || (pop && !push && w_empty);
        w_wr_idx  = AW'(r_count);
        w_rd_idx  = AW'(r_count - CW'(1));
    end

    // Stack storage: written on a qualified push only.
    // NOTE: storage is deliberately not reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    // Occupancy counter: up on push, down on pop, aborted by reset.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_push_ok) begin
            r_count <= r_count + CW'(1);
        end else if (w_pop_ok) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Sticky misuse flag: a new error wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_error) begin
            r_err <= 1'b1;
        end else if (clr_err) begin
            r_err <= 1'b0;
        end
    end

    assign dout   = r_mem[w_rd_idx];
    assign count  = r_count;
    assign full   = w_full;
    assign empty  = w_empty;
    assign pop_ok = w_pop_ok;
    assign err    = r_err;

endmodule

// File: rtl/flag_unit.sv
// Flag unit: registers the ALU carry/overflow/zero flags, evaluates branch
// conditions from the registered flags, and saves/restores the flag word
// through a small LIFO for subroutine calls and interrupts.
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_carry,
    input  logic          alu_overflow,
    input  logic          alu_zero,
    input  logic          we_flags,
    input  logic [2:0]    cond,
    output logic          take,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_err,
    output logic [2:0]    flags,
    output logic [CW-1:0] count,
    output logic          stack_full,
    output logic          stack_empty,
    output logic          err
);

    flags_t        r_flags;

    flags_t        w_alu_flags;
    flags_t        w_stack_top;
    logic          w_pop_ok;
    logic          w_take;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_err;

    // Save stack; it always captures the flag word as it was before the edge.
    flag_stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .clr_err (clr_err),
        .din     (r_flags),
        .dout    (w_stack_top),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty),
        .pop_ok  (w_pop_ok),
        .err     (w_err)
    );

    // Gather the ALU status bits into a flag word.
    always_comb begin
        w_alu_flags = pack_flags(alu_carry, alu_overflow, alu_zero);
    end

    // Flag register: a successful restore beats an ALU load, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= '0;
        end else if (w_pop_ok) begin
            r_flags <= w_stack_top;
        end else if (we_flags) begin
            r_flags <= w_alu_flags;
        end
    end

    // Branch condition mux, combinational from the registered flags.
    always_comb begin
        w_take = 1'b0;
        case (cond_e'(cond))
            COND_ALWAYS: w_take = 1'b1;
            COND_Z:      w_take = r_flags[FLAG_Z];
            COND_NZ:     w_take = !r_flags[FLAG_Z];
            COND_C:      w_take = r_flags[FLAG_C];
            COND_NC:     w_take = !r_flags[FLAG_C];
            COND_V:      w_take = r_flags[FLAG_V];
            COND_NV:     w_take = !r_flags[FLAG_V];
            COND_NEVER:  w_take = 1'b0;
            default:     w_take = 1'b0;
        endcase
    end

    assign take        = w_take;
    assign flags       = r_flags;
    assign count       = w_count;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;
    assign err         = w_err;

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Consumer end of the ALU status outputs: latches carry/overflow/zero into a registered flag word.
- Evaluates branch conditions for the single-cycle CPU control path from the registered flags.
- Provides a small LIFO that saves and restores flags across subroutine calls and interrupts.
- Sits between the ALU flag outputs and the PC/jump-select logic.

Parameters:
- DEPTH, 4, number of flag words the save stack holds (≥2).
- CW, computed as $clog2(DEPTH+1), width of the occupancy count (localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- alu_carry  input  1  carry flag from the ALU.
- alu_overflow  input  1  overflow flag from the ALU.
- alu_zero  input  1  zero flag from the ALU.
- we_flags  input  1  load the ALU flags into the flag register this cycle.
- cond  input  3  condition selector for take.
- take  output  1  condition result, combinational from the flag register.
- push  input  1  save the flag register onto the stack.
- pop  input  1  restore the flag register from the stack top.
- clr_err  input  1  synchronous clear of err.
- flags  output  3  registered {carry, overflow, zero}.
- count  output  CW  stack occupancy.
- stack_full  output  1  count == DEPTH.
- stack_empty  output  1  count == 0.
- err  output  1  sticky stack misuse flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - flags=3'b000, count=0, err=0; therefore stack_empty=1, stack_full=0.
  - Stack storage contents are don't-care.
  - Reset asserted mid-operation aborts any push/pop in that cycle.
- Flag register update, priority per rising edge:
  1. pop && !push && !stack_empty: flags ← stack[count-1]; count ← count-1. we_flags is ignored this cycle.
  2. else if we_flags: flags ← {alu_carry, alu_overflow, alu_zero}.
  3. else: hold.
- push && !pop && !stack_full:
  - stack[count] ← flags value before this edge; count ← count+1.
  - A push with we_flags saves the old flags and loads the new ALU flags in the same edge.
- push && pop in the same cycle: stack and count unchanged, err unchanged. Flags follow rule 2/3, so we_flags still applies.
- Overflow/underflow:
  - push (alone) with stack_full: no write, count holds, err ← 1.
  - pop (alone) with stack_empty: flags hold, or load from ALU if we_flags; count stays 0; err ← 1.
- err:
  - Sticky until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the set wins (err=1).
- take (combinational, zero latency from flags/cond). Encoding:
  - 000 always 1
  - 001 Z=1
  - 010 Z=0
  - 011 C=1
  - 100 C=0
  - 101 V=1
  - 110 V=0
  - 111 never (0)
- Width and indexing:
  - Stack index = count-1 / count, computed in CW bits.
  - No wrap-around: full and empty guards make it impossible.
- stack_full and stack_empty are decoded combinationally from count. No other outputs are combinational from inputs except take, which depends on cond.

Decomposition:
- Shared package:
  - Condition codes as named constants: COND_ALWAYS, COND_Z, COND_NZ, COND_C, COND_NC, COND_V, COND_NV, COND_NEVER.
  - Flag bit positions: FLAG_C=2, FLAG_V=1, FLAG_Z=0.
  - These are reused by the control decoder.
- One natural sub-module: flag_stack, the parameterised LIFO with push/pop/count/full/empty/err.
- The flag register and the condition mux stay in the top-level flag_unit.

Test Plan:
- Reset then we_flags with C=1,V=0,Z=1 → next cycle flags=3'b101; take=1 for cond 001 and 011; take=0 for cond 010, 100, 101, 111.
- flags=3'b001; push with we_flags (new 3'b110) → flags=3'b110, count=1; then pop → flags=3'b001, count=0, stack_empty=1.
- With DEPTH=4, push 4 distinct words (3'b001, 010, 011, 100):
  - after the 4th push, stack_full=1.
  - 5th push → err=1, count=4.
  - pops return 100, 011, 010, 001 in order.
- pop at count=0 with we_flags=1 and ALU=3'b010 → flags=3'b010, count=0, err=1.
  - clr_err next cycle → err=0.
  - clr_err with a simultaneous underflow pop → err stays 1.
- push and pop together at count=2 → count=2, stack contents unchanged, err=0; a concurrent we_flags still loads the ALU flags.
- Assert reset asynchronously mid-cycle at count=3, flags=3'b111 → flags=0, count=0, err=0 immediately, with no clock edge required.
